// File: rtl/leb128_decoder_pkg.sv
// Shared definitions for the byte-serial LEB128 immediate decoder.
package leb128_decoder_pkg;

    // Decoder control states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2,
        StErr   = 2'd3
    } leb_state_e;

    // Longest legal encodings: ceil(32/7) and ceil(64/7) bytes.
    localparam logic [3:0] LebMaxLen32 = 4'd5;
    localparam logic [3:0] LebMaxLen64 = 4'd10;

    // Bit offset of a byte's payload: 7 * index, built from shift and subtract.
    function automatic logic [6:0] payload_shift(input logic [3:0] idx);
        logic [6:0] idx7;
        idx7 = {3'b000, idx};
        return (idx7 << 3) - idx7;
    endfunction

endpackage

// File: rtl/leb128_decoder_final_check.sv
// Padding rule for the last byte of a maximum-length LEB128 encoding: the
// payload bits that lie beyond the target width must be zero (unsigned) or
// copies of the sign bit (signed).
module leb128_decoder_final_check (
    input  logic [6:0] payload,
    input  logic       signed_mode,
    input  logic       width64,
    output logic       ok
);

    // Decode the four target formats into a single pass/fail flag.
    always_comb begin
        ok = 1'b0;
        unique case ({width64, signed_mode})
            2'b00: ok = (payload[6:4] == 3'b000);
            2'b01: ok = (payload[6:3] == 4'h0) || (payload[6:3] == 4'hF);
            2'b10: ok = (payload[6:1] == 6'h00);
            2'b11: ok = (payload[6:0] == 7'h00) || (payload[6:0] == 7'h7F);
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 decoder: accepts one code byte per cycle, accumulates the
// 7-bit groups, and presents the decoded value and consumed length to the cpu.
module leb128_decoder
    import leb128_decoder_pkg::*;
#(
    parameter bit USE_64B = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_mode,
    input  logic        width64,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_value,
    output logic [3:0]  out_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        error
);

    leb_state_e  state_q, state_d;
    logic        signed_q, signed_d;
    logic        wide_q, wide_d;
    logic [63:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] value_q, value_d;
    logic [3:0]  len_q, len_d;

    logic [6:0]  shamt;
    logic [6:0]  next_shamt;
    logic [3:0]  count_inc;
    logic [3:0]  max_len;
    logic        at_max;
    logic [63:0] acc_new;
    logic [63:0] ext_mask;
    logic [63:0] extended;
    logic [63:0] result;
    logic        final_ok;

    leb128_decoder_final_check u_final_check (
        .payload     (in_byte[6:0]),
        .signed_mode (signed_q),
        .width64     (wide_q),
        .ok          (final_ok)
    );

    // Datapath for the byte currently offered: OR-in, sign extension, width.
    always_comb begin
        count_inc  = count_q + 4'd1;
        shamt      = payload_shift(count_q);
        next_shamt = shamt + 7'd7;
        max_len    = wide_q ? LebMaxLen64 : LebMaxLen32;
        at_max     = (count_inc == max_len);
        acc_new    = acc_q | ({57'd0, in_byte[6:0]} << shamt);
        // Shift amounts of 64 and above yield an empty mask.
        ext_mask   = ~64'd0 << next_shamt;
        extended   = (signed_q && in_byte[6]) ? (acc_new | ext_mask) : acc_new;
        result     = wide_q ? extended : {32'd0, extended[31:0]};
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        wide_d   = wide_q;
        acc_d    = acc_q;
        count_d  = count_q;
        value_d  = value_q;
        len_d    = len_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StAccum;
                    signed_d = signed_mode;
                    wide_d   = width64 & USE_64B;
                    acc_d    = 64'd0;
                    count_d  = 4'd0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    acc_d   = acc_new;
                    count_d = count_inc;
                    if (!in_byte[7]) begin
                        // Padding only matters on a maximum-length encoding.
                        if (!at_max || final_ok) begin
                            state_d = StDone;
                            value_d = result;
                            len_d   = count_inc;
                        end else begin
                            state_d = StErr;
                        end
                    end else if (at_max) begin
                        state_d = StErr;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous abort on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            signed_q <= 1'b0;
            wide_q   <= 1'b0;
            acc_q    <= 64'd0;
            count_q  <= 4'd0;
            value_q  <= 64'd0;
            len_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            wide_q   <= wide_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            value_q  <= value_d;
            len_q    <= len_d;
        end
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        error     = (state_q == StErr);
        out_value = value_q;
        out_len   = len_q;
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Scoreboard bench for leb128_decoder: stimulus pushes expected results,
// a negedge monitor pops and compares on every result or error pulse.
module tb_leb128_decoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic        width64;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        out_ready;
    logic        error;

    typedef struct {
        bit          err;
        logic [63:0] val;
        logic [3:0]  len;
    } exp_t;

    exp_t       exp_q[$];
    int         checks;
    int         failures;
    bit         tmo_req;
    bit         end_req;
    bit         end_done;
    logic [7:0] v [10];

    leb128_decoder #(
        .USE_64B (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_mode (signed_mode),
        .width64     (width64),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_value   (out_value),
        .out_len     (out_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        exp_t        e;
        bit          err_prev;
        bit          vld_prev;
        bit          rdy_prev;
        logic [63:0] hold_val;
        logic [3:0]  hold_len;
        checks   = 0;
        failures = 0;
        end_done = 1'b0;
        err_prev = 1'b0;
        vld_prev = 1'b0;
        rdy_prev = 1'b0;
        hold_val = '0;
        hold_len = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0 || error !== 1'b0 ||
                    out_value !== 64'd0 || out_len !== 4'd0) begin
                    failures++;
                    $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b val=%h len=%0d, want all 0",
                             in_ready, out_valid, error, out_value, out_len);
                end
            end else begin
                if (error) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_error: got error pulse, want none pending");
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.err) begin
                            failures++;
                            $display("FAIL error_vs_result: got error, want val=%h len=%0d",
                                     e.val, e.len);
                        end
                    end
                    checks++;
                    if (err_prev || out_valid) begin
                        failures++;
                        $display("FAIL error_shape: got prev_err=%b vld=%b, want 0 0",
                                 err_prev, out_valid);
                    end
                end
                if (out_valid && vld_prev && !rdy_prev) begin
                    checks++;
                    if (out_value !== hold_val || out_len !== hold_len) begin
                        failures++;
                        $display("FAIL hold_stable: got val=%h len=%0d, want val=%h len=%0d",
                                 out_value, out_len, hold_val, hold_len);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result: got val=%h len=%0d, want nothing",
                                 out_value, out_len);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.err || out_value !== e.val || out_len !== e.len) begin
                            failures++;
                            $display("FAIL result: got val=%h len=%0d, want err=%b val=%h len=%0d",
                                     out_value, out_len, e.err, e.val, e.len);
                        end
                    end
                end
            end
            if (tmo_req) begin
                checks++;
                failures++;
                $display("FAIL timeout: got no out_valid/error in budget, want one");
            end
            if (end_req && !end_done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL leftover: got %0d pending expectations, want 0", exp_q.size());
                end
                end_done = 1'b1;
            end
            err_prev = error;
            vld_prev = out_valid;
            rdy_prev = out_ready;
            hold_val = out_value;
            hold_len = out_len;
        end
    end

    // Issue one decode of v[0..n-1], with optional byte gaps and result hold-off.
    task automatic run_vec(input bit sm, input bit w64, input int n, input bit exp_err,
                           input logic [63:0] val, input logic [3:0] len,
                           input int gap, input int hold);
        exp_t e;
        int   t;
        e.err = exp_err;
        e.val = val;
        e.len = len;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start       = 1'b1;
        signed_mode = sm;
        width64     = w64;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_byte  = v[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_byte  = 8'h00;
            if (i < n - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        t = 0;
        while (!out_valid && !error && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (out_valid) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end else if (error) begin
            @(posedge clk); #1;
        end else begin
            tmo_req = 1'b1;
            @(posedge clk); #1;
            tmo_req = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        width64     = 1'b0;
        in_byte     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        tmo_req     = 1'b0;
        end_req     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        v = '{0: 8'hE5, 1: 8'h8E, 2: 8'h26, default: 8'h00};
        run_vec(1'b0, 1'b0, 3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 0, 0);
        v = '{0: 8'h7F, default: 8'h00};
        run_vec(1'b1, 1'b1, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 0, 0);
        run_vec(1'b1, 1'b0, 1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd1, 0, 0);
        v = '{0: 8'hC0, 1: 8'hBB, 2: 8'h78, default: 8'h00};
        run_vec(1'b1, 1'b1, 3, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 0, 0);
        v = '{0: 8'hFF, 1: 8'hFF, 2: 8'hFF, 3: 8'hFF, 4: 8'h0F, default: 8'h00};
        run_vec(1'b0, 1'b0, 5, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 0, 0);
        v = '{0: 8'hFF, 1: 8'hFF, 2: 8'hFF, 3: 8'hFF, 4: 8'h1F, default: 8'h00};
        run_vec(1'b0, 1'b0, 5, 1'b1, 64'd0, 4'd0, 0, 0);
        v = '{0: 8'h80, 1: 8'h80, 2: 8'h80, 3: 8'h80, 4: 8'h80, default: 8'h00};
        run_vec(1'b0, 1'b0, 5, 1'b1, 64'd0, 4'd0, 0, 0);
        v = '{9: 8'h01, default: 8'h80};
        run_vec(1'b0, 1'b1, 10, 1'b0, 64'h8000_0000_0000_0000, 4'd10, 0, 0);
        v = '{9: 8'h02, default: 8'h80};
        run_vec(1'b0, 1'b1, 10, 1'b1, 64'd0, 4'd0, 0, 0);
        v = '{0: 8'hFF, 1: 8'hFF, 2: 8'hFF, 3: 8'hFF, 4: 8'h7F, default: 8'h00};
        run_vec(1'b1, 1'b0, 5, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 0, 0);
        v = '{0: 8'hFF, 1: 8'hFF, 2: 8'hFF, 3: 8'hFF, 4: 8'h4F, default: 8'h00};
        run_vec(1'b1, 1'b0, 5, 1'b1, 64'd0, 4'd0, 0, 0);
        v = '{0: 8'hE5, 1: 8'h8E, 2: 8'h26, default: 8'h00};
        run_vec(1'b0, 1'b1, 3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 0, 0);
        // Gapped input and delayed consumer.
        run_vec(1'b0, 1'b0, 3, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 2, 5);

        // Abort mid-decode after two bytes; no result or error expected.
        @(posedge clk); #1;
        start       = 1'b1;
        signed_mode = 1'b0;
        width64     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_byte  = v[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        v = '{0: 8'h02, default: 8'h00};
        run_vec(1'b0, 1'b0, 1, 1'b0, 64'd2, 4'd1, 0, 0);

        end_req = 1'b1;
        while (!end_done) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
